// File: rtl/teletext_frame_scanner.sv
// rtl/teletext_frame_scanner.sv - scans a COLUMNS x ROWS character framebuffer into a teletext character stream plus timing strobes.
// Optional TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN adds a 6-bit frame_count output for blink timing.
module teletext_frame_scanner #(
    parameter int COLUMNS           = 40,
    parameter int ROWS              = 25,
    parameter int SCANLINES_PER_ROW = 10,
    parameter int BLANK_CYCLES      = 8,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                  clk,
    input  logic                  clk__enable,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  smoothe_mode,
    output logic                  fb_select,
    output logic [ADDR_WIDTH-1:0] fb_address,
    input  logic [6:0]            fb_data,
    output logic                  character__valid,
    output logic [6:0]            character__character,
    output logic                  timings__restart_frame,
    output logic                  timings__end_of_scanline,
    output logic                  timings__first_scanline_of_row,
    output logic                  timings__smoothe,
`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
    output logic [5:0]            frame_count,
`endif
    output logic [1:0]            timings__interpolate_vertical
);

    localparam int COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int LINE_W  = $clog2(2 * SCANLINES_PER_ROW);
    localparam int BLANK_W = $clog2(BLANK_CYCLES);

    typedef enum logic [2:0] {IDLE, FRAME_START, FETCH, DRAIN, LINE_END, BLANK} state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [LINE_W-1:0]     scanline_q, scanline_d;
    logic [LINE_W-1:0]     last_line;
    logic [BLANK_W-1:0]    blank_q, blank_d;
    logic                  drain_q, drain_d;
    logic                  fb_select_q, fb_select_d;
    logic [ADDR_WIDTH-1:0] fb_address_q, fb_address_d;
    logic                  rd_pending_q, rd_pending_d;
    logic                  char_valid_q, char_valid_d;
    logic [6:0]            char_q, char_d;
    logic                  restart_q, restart_d;
    logic                  eos_q, eos_d;
    logic                  first_q, first_d;
    logic                  smoothe_q, smoothe_d;
    logic [1:0]            interp_q, interp_d;
    logic [5:0]            frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        row_base_d    = row_base_q;
        scanline_d    = scanline_q;
        blank_d       = blank_q;
        drain_d       = drain_q;
        smoothe_d     = smoothe_q;
        frame_count_d = frame_count_q;
        last_line     = smoothe_q ? LINE_W'(2 * SCANLINES_PER_ROW - 1)
                                  : LINE_W'(SCANLINES_PER_ROW - 1);

        case (state_q)
            IDLE: begin
                if (enable) state_d = FRAME_START;
            end
            FRAME_START: begin
                frame_count_d = frame_count_q + 6'd1;
                state_d       = FETCH;
            end
            FETCH: begin
                if (col_q == COL_W'(COLUMNS - 1)) begin
                    col_d   = '0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = LINE_END;
                end else begin
                    drain_d = 1'b1;
                end
            end
            LINE_END: begin
                if (scanline_q == last_line) begin
                    scanline_d = '0;
                    row_d      = row_q + ROW_W'(1);
                    row_base_d = row_base_q + ADDR_WIDTH'(COLUMNS);
                end else begin
                    scanline_d = scanline_q + LINE_W'(1);
                end
                blank_d = '0;
                state_d = BLANK;
            end
            BLANK: begin
                if (blank_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                    blank_d = '0;
                    if (row_q != ROW_W'(ROWS)) state_d = FETCH;
                    else if (enable)           state_d = FRAME_START;
                    else                       state_d = IDLE;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame parameters are latched on entry so they are visible during the FRAME_START cycle itself.
        if (state_d == FRAME_START) begin
            row_d      = '0;
            scanline_d = '0;
            row_base_d = '0;
            smoothe_d  = smoothe_mode;
        end

        // Outputs are registered from next-state values so they line up with the state they describe.
        fb_select_d  = (state_d == FETCH);
        fb_address_d = row_base_d + ADDR_WIDTH'(col_d);
        rd_pending_d = fb_select_q;
        char_valid_d = rd_pending_q;
        char_d       = rd_pending_q ? fb_data : char_q;
        restart_d    = (state_d == FRAME_START);
        eos_d        = (state_d == LINE_END);
        first_d      = (state_d != IDLE) && (scanline_d == '0);
        interp_d     = ((state_d != IDLE) && smoothe_d && scanline_d[0]) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            row_base_q    <= '0;
            scanline_q    <= '0;
            blank_q       <= '0;
            drain_q       <= 1'b0;
            fb_select_q   <= 1'b0;
            fb_address_q  <= '0;
            rd_pending_q  <= 1'b0;
            char_valid_q  <= 1'b0;
            char_q        <= '0;
            restart_q     <= 1'b0;
            eos_q         <= 1'b0;
            first_q       <= 1'b0;
            smoothe_q     <= 1'b0;
            interp_q      <= 2'b00;
            frame_count_q <= '0;
        end else if (clk__enable) begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            row_base_q    <= row_base_d;
            scanline_q    <= scanline_d;
            blank_q       <= blank_d;
            drain_q       <= drain_d;
            fb_select_q   <= fb_select_d;
            fb_address_q  <= fb_address_d;
            rd_pending_q  <= rd_pending_d;
            char_valid_q  <= char_valid_d;
            char_q        <= char_d;
            restart_q     <= restart_d;
            eos_q         <= eos_d;
            first_q       <= first_d;
            smoothe_q     <= smoothe_d;
            interp_q      <= interp_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fb_select                      = fb_select_q;
    assign fb_address                     = fb_address_q;
    assign character__valid               = char_valid_q;
    assign character__character           = char_q;
    assign timings__restart_frame         = restart_q;
    assign timings__end_of_scanline       = eos_q;
    assign timings__first_scanline_of_row = first_q;
    assign timings__smoothe               = smoothe_q;
    assign timings__interpolate_vertical  = interp_q;

`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
    assign frame_count = frame_count_q;
`else
    logic unused_frame_count;
    assign unused_frame_count = ^frame_count_q;
`endif

endmodule

// File: tb/tb_teletext_frame_scanner.sv
// tb/tb_teletext_frame_scanner.sv - scoreboard bench for teletext_frame_scanner on a 4x2 framebuffer.
module tb_teletext_frame_scanner;

    localparam int COLS = 4;
    localparam int NROW = 2;
    localparam int SPR  = 2;
    localparam int BLK  = 2;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          clk__enable = 1'b1;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          smoothe_mode = 1'b0;
    logic          fb_select;
    logic [AW-1:0] fb_address;
    logic [6:0]    fb_data = '0;
    logic          ch_valid;
    logic [6:0]    ch_char;
    logic          restart, eos, first_sl, smoothe;
    logic [1:0]    interp;
`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
    logic [5:0]    frame_count;
`endif

    typedef struct {
        logic [6:0] ch;
        logic       first;
        logic [1:0] iv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Framebuffer model: address a holds character code a.
    always @(posedge clk) if (fb_select) fb_data <= 7'(fb_address);

    teletext_frame_scanner #(
        .COLUMNS(COLS), .ROWS(NROW), .SCANLINES_PER_ROW(SPR),
        .BLANK_CYCLES(BLK), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .clk__enable(clk__enable),
        .reset(reset),
        .enable(enable),
        .smoothe_mode(smoothe_mode),
        .fb_select(fb_select),
        .fb_address(fb_address),
        .fb_data(fb_data),
        .character__valid(ch_valid),
        .character__character(ch_char),
        .timings__restart_frame(restart),
        .timings__end_of_scanline(eos),
        .timings__first_scanline_of_row(first_sl),
        .timings__smoothe(smoothe),
`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
        .frame_count(frame_count),
`endif
        .timings__interpolate_vertical(interp)
    );

    task automatic test_reset();
        logic [AW+17:0] outs;
        reset = 1'b1; enable = 1'b1; smoothe_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {fb_select, fb_address, ch_valid, ch_char, restart, eos, first_sl, smoothe, interp};
            n_checks++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({restart, fb_select} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_restart: restart/fb_select got %b expected 10", {restart, fb_select});
        end
        @(negedge clk);
        n_checks++;
        if ({restart, fb_select, fb_address} !== {2'b01, AW'(0)}) begin
            n_fail++;
            $display("FAIL reset_first_fetch: restart/fb_select/addr got %b/%b/%0d expected 0/1/0",
                     restart, fb_select, fb_address);
        end
    endtask

    task automatic scan_frame(input bit smooth, input bit drop);
        int   lpr, frame_len, n_cyc, eos_cnt, rst_cnt, first_rst, second_rst;
        bit   prev_valid;
        exp_t e;
        lpr       = smooth ? 2 * SPR : SPR;
        frame_len = 1 + NROW * lpr * (COLS + 3 + BLK);
        exp_q.delete();
        for (int r = 0; r < NROW; r++)
            for (int l = 0; l < lpr; l++)
                for (int c = 0; c < COLS; c++) begin
                    e.ch    = 7'(r * COLS + c);
                    e.first = (l == 0);
                    e.iv    = (smooth && (l % 2 == 1)) ? 2'b01 : 2'b00;
                    exp_q.push_back(e);
                end
        smoothe_mode = smooth; enable = 1'b1; reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        eos_cnt = 0; rst_cnt = 0; prev_valid = 1'b0; first_rst = -1; second_rst = -1;
        n_cyc = drop ? 2 * frame_len : frame_len + 20;
        for (int cyc = 1; cyc <= n_cyc; cyc++) begin
            @(negedge clk);
            if (drop && cyc == 10) enable = 1'b0;
            if (restart) begin
                rst_cnt++;
                if (first_rst < 0) first_rst = cyc;
                else if (second_rst < 0) second_rst = cyc;
            end
            if (rst_cnt == 1 && ch_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_char: got char %0d with nothing expected", ch_char);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_char !== e.ch || first_sl !== e.first || interp !== e.iv) begin
                        n_fail++;
                        $display("FAIL char_stream cyc %0d: char/first/interp got %0d/%b/%b expected %0d/%b/%b",
                                 cyc, ch_char, first_sl, interp, e.ch, e.first, e.iv);
                    end
                end
            end
            if (rst_cnt == 1 && eos) begin
                eos_cnt++;
                n_checks++;
                if (!(prev_valid && !ch_valid)) begin
                    n_fail++;
                    $display("FAIL eos_align cyc %0d: prev_valid/valid got %b/%b expected 1/0",
                             cyc, prev_valid, ch_valid);
                end
            end
            prev_valid = ch_valid;
        end
        n_checks++;
        if (exp_q.size() != 0 || eos_cnt != NROW * lpr) begin
            n_fail++;
            $display("FAIL frame_totals: leftover chars %0d eos %0d expected 0 and %0d",
                     exp_q.size(), eos_cnt, NROW * lpr);
        end
        n_checks++;
        if (first_rst != 1) begin
            n_fail++;
            $display("FAIL restart_latency: first restart at cycle %0d expected 1", first_rst);
        end
        n_checks++;
        if (smoothe !== smooth) begin
            n_fail++;
            $display("FAIL smoothe_latch: got %b expected %b", smoothe, smooth);
        end
        if (drop) begin
            n_checks++;
            if (rst_cnt != 1 || fb_select !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_drop_idle: restarts %0d fb_select %b expected 1 and 0", rst_cnt, fb_select);
            end
        end else begin
            n_checks++;
            if (second_rst - first_rst != frame_len) begin
                n_fail++;
                $display("FAIL frame_length: got %0d cycles expected %0d", second_rst - first_rst, frame_len);
            end
        end
    endtask

    task automatic test_normal_frame();
        scan_frame(1'b0, 1'b0);
    endtask

    task automatic test_smoothe_frame();
        scan_frame(1'b1, 1'b0);
    endtask

    task automatic test_enable_drop();
        scan_frame(1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        bit found;
        smoothe_mode = 1'b0; enable = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (fb_select && fb_address == AW'(2)) found = 1'b1;
        end
        n_checks++;
        if (!found || ch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_reach_col2: found %b valid %b expected 1/1", found, ch_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fb_select, ch_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_clear: fb_select/valid got %b expected 00", {fb_select, ch_valid});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (restart !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart: got %b expected 1", restart);
        end
        @(negedge clk);
        n_checks++;
        if (fb_select !== 1'b1 || fb_address !== AW'(0)) begin
            n_fail++;
            $display("FAIL midreset_addr: fb_select/addr got %b/%0d expected 1/0", fb_select, fb_address);
        end
    endtask

`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
    task automatic test_frame_count();
        int k;
        smoothe_mode = 1'b0; enable = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 3000 && k < 66; cyc++) begin
            @(negedge clk);
            if (restart) begin
                n_checks++;
                if (frame_count !== 6'(k % 64)) begin
                    n_fail++;
                    $display("FAIL frame_count pulse %0d: got %0d expected %0d", k, frame_count, k % 64);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 66) begin
            n_fail++;
            $display("FAIL frame_count_pulses: got %0d expected 66", k);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_frame();
        test_smoothe_frame();
        test_enable_drop();
        test_reset_midframe();
`ifdef TELETEXT_FRAME_SCANNER_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
